// File: rtl/user_core_sequencer.sv
// Run controller for the user-area RV32I core: streams program words into imem,
// holds the core in reset while loading, then runs it under a cycle watchdog.
module user_core_sequencer #(
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 24
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               abort,
  input  logic [IMEM_AW:0]   prog_len,
  input  logic [CNT_W-1:0]   cycle_limit,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst,
  input  logic               core_halt,
  input  logic [15:0]        core_result,
  output logic [3:0]         status,
  output logic [15:0]        checkbits,
  output logic               busy,
  output logic [CNT_W-1:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [IMEM_AW:0] MAX_LEN = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] LEN_ONE = (IMEM_AW + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state, next_state;
  logic [IMEM_AW:0]   len_q;
  logic [IMEM_AW:0]   word_cnt;
  logic [CNT_W-1:0]   limit_q;
  logic [IMEM_AW:0]   len_clamped;
  logic               can_start;
  logic               handshake;
  logic               last_word;
  logic               limit_hit;

  function automatic logic [3:0] status_code(state_t s);
    case (s)
      S_LOAD, S_ARM: return 4'h1;
      S_RUN:         return 4'hA;
      S_DONE:        return 4'h5;
      S_FAULT:       return 4'hE;
      default:       return 4'h0;
    endcase
  endfunction

  assign can_start   = start && (state == S_IDLE || state == S_DONE || state == S_FAULT);
  assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign handshake   = ld_valid && ld_ready;
  assign last_word   = (word_cnt == len_q - LEN_ONE);
  assign limit_hit   = (limit_q != '0) && (cycles == limit_q - CNT_ONE);

  assign ld_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_ARM) || (state == S_RUN);

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking here would race.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state defaults to state before the case, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT:
          if (can_start) next_state = (len_clamped != '0) ? S_LOAD : S_ARM;
        S_LOAD:
          if (handshake && last_word) next_state = S_ARM;
        S_ARM:
          next_state = S_RUN;
        S_RUN:
          if (core_halt)      next_state = S_DONE;
          else if (limit_hit) next_state = S_FAULT;
        default:
          next_state = S_IDLE;
      endcase
    end
  end

  // Registered outputs are computed from next_state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_rst   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      status     <= 4'h0;
      checkbits  <= 16'h0000;
      cycles     <= '0;
      len_q      <= '0;
      limit_q    <= '0;
      word_cnt   <= '0;
    end else begin
      status  <= status_code(next_state);
      imem_we <= 1'b0;
      if (abort) begin
        checkbits <= 16'h0000;
        core_rst  <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_FAULT: begin
            if (can_start) begin
              len_q     <= len_clamped;
              limit_q   <= cycle_limit;
              word_cnt  <= '0;
              cycles    <= '0;
              checkbits <= 16'hAB40;
              core_rst  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (handshake) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[IMEM_AW-1:0];
              imem_wdata <= ld_data;
              word_cnt   <= word_cnt + LEN_ONE;
            end
          end
          S_ARM: begin
            core_rst <= 1'b0;
          end
          S_RUN: begin
            if (!(&cycles)) cycles <= cycles + CNT_ONE;
            if (core_halt) begin
              checkbits <= core_result;
              core_rst  <= 1'b1;
            end else if (limit_hit) begin
              checkbits <= 16'hDEAD;
              core_rst  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_core_sequencer.sv
// Directed bench for user_core_sequencer: load, run, halt, watchdog, stall,
// zero-length, abort and reset scenarios with hand-computed expectations.
module tb_user_core_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start, abort, ld_valid, core_halt;
  logic [8:0]  prog_len;
  logic [23:0] cycle_limit;
  logic [31:0] ld_data;
  logic [15:0] core_result;
  logic        ld_ready, imem_we, core_rst, busy;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [3:0]  status;
  logic [15:0] checkbits;
  logic [23:0] cycles;

  int checks   = 0;
  int failures = 0;

  user_core_sequencer #(.IMEM_AW(8), .CNT_W(24)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .prog_len(prog_len), .cycle_limit(cycle_limit), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .core_halt(core_halt), .core_result(core_result), .status(status),
    .checkbits(checkbits), .busy(busy), .cycles(cycles)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Checks the full reset-value set; used after power-on and mid-run reset.
  task automatic expect_reset_values(input string tag);
    checks++; if (status !== 4'h0)       begin failures++; $display("FAIL %s_status got=%h exp=0", tag, status); end
    checks++; if (checkbits !== 16'h0)   begin failures++; $display("FAIL %s_checkbits got=%h exp=0", tag, checkbits); end
    checks++; if (core_rst !== 1'b1)     begin failures++; $display("FAIL %s_core_rst got=%b exp=1", tag, core_rst); end
    checks++; if (ld_ready !== 1'b0)     begin failures++; $display("FAIL %s_ld_ready got=%b exp=0", tag, ld_ready); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
    checks++; if (imem_we !== 1'b0)      begin failures++; $display("FAIL %s_imem_we got=%b exp=0", tag, imem_we); end
    checks++; if (imem_addr !== 8'h0)    begin failures++; $display("FAIL %s_imem_addr got=%h exp=0", tag, imem_addr); end
    checks++; if (imem_wdata !== 32'h0)  begin failures++; $display("FAIL %s_imem_wdata got=%h exp=0", tag, imem_wdata); end
    checks++; if (cycles !== 24'h0)      begin failures++; $display("FAIL %s_cycles got=%0d exp=0", tag, cycles); end
  endtask

  task automatic pulse_start(input logic [8:0] len, input logic [23:0] lim);
    prog_len = len; cycle_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; start = 0; abort = 0; ld_valid = 0; core_halt = 0;
    prog_len = '0; cycle_limit = '0; ld_data = '0; core_result = '0;
    ticks(2);
    expect_reset_values("reset");
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [31:0] words [3] = '{32'h0000_0093, 32'h0010_0113, 32'h0020_8193};
    ld_valid = 1'b1; ld_data = words[0];
    pulse_start(9'd3, 24'd0);
    checks++; if (status !== 4'h1)        begin failures++; $display("FAIL load_status got=%h exp=1", status); end
    checks++; if (checkbits !== 16'hAB40) begin failures++; $display("FAIL load_marker got=%h exp=ab40", checkbits); end
    checks++; if (ld_ready !== 1'b1)      begin failures++; $display("FAIL load_ready got=%b exp=1", ld_ready); end
    checks++; if (imem_we !== 1'b0)       begin failures++; $display("FAIL load_we_idle got=%b exp=0", imem_we); end
    for (int i = 0; i < 3; i++) begin
      ld_data = words[i];
      tick();
      checks++; if (imem_we !== 1'b1)         begin failures++; $display("FAIL load_we%0d got=%b exp=1", i, imem_we); end
      checks++; if (imem_addr !== 8'(i))      begin failures++; $display("FAIL load_addr%0d got=%0d exp=%0d", i, imem_addr, i); end
      checks++; if (imem_wdata !== words[i])  begin failures++; $display("FAIL load_data%0d got=%h exp=%h", i, imem_wdata, words[i]); end
    end
    ld_valid = 1'b0;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL arm_ready got=%b exp=0", ld_ready); end
    checks++; if (status !== 4'h1)   begin failures++; $display("FAIL arm_status got=%h exp=1", status); end
    checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL arm_core_rst got=%b exp=1", core_rst); end
    tick();
    checks++; if (status !== 4'hA)   begin failures++; $display("FAIL run_status got=%h exp=a", status); end
    checks++; if (core_rst !== 1'b0) begin failures++; $display("FAIL run_core_rst got=%b exp=0", core_rst); end
    checks++; if (imem_we !== 1'b0)  begin failures++; $display("FAIL run_we got=%b exp=0", imem_we); end
    checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL run_busy got=%b exp=1", busy); end
  endtask

  task automatic test_halt();
    ticks(49);
    checks++; if (cycles !== 24'd49) begin failures++; $display("FAIL halt_pre_cycles got=%0d exp=49", cycles); end
    core_halt = 1'b1; core_result = 16'h1968;
    tick();
    core_halt = 1'b0; core_result = 16'h0;
    checks++; if (status !== 4'h5)        begin failures++; $display("FAIL halt_status got=%h exp=5", status); end
    checks++; if (checkbits !== 16'h1968) begin failures++; $display("FAIL halt_result got=%h exp=1968", checkbits); end
    checks++; if (cycles !== 24'd50)      begin failures++; $display("FAIL halt_cycles got=%0d exp=50", cycles); end
    checks++; if (core_rst !== 1'b1)      begin failures++; $display("FAIL halt_core_rst got=%b exp=1", core_rst); end
    ticks(3);
    checks++; if (status !== 4'h5 || checkbits !== 16'h1968 || cycles !== 24'd50 || busy !== 1'b0)
      begin failures++; $display("FAIL done_hold got=%h/%h/%0d exp=5/1968/50", status, checkbits, cycles); end
  endtask

  task automatic test_watchdog();
    pulse_start(9'd0, 24'd10);
    tick();
    checks++; if (status !== 4'hA) begin failures++; $display("FAIL wd_run got=%h exp=a", status); end
    ticks(9);
    checks++; if (status !== 4'hA || cycles !== 24'd9) begin failures++; $display("FAIL wd_pre got=%h/%0d exp=a/9", status, cycles); end
    tick();
    checks++; if (status !== 4'hE)        begin failures++; $display("FAIL wd_status got=%h exp=e", status); end
    checks++; if (checkbits !== 16'hDEAD) begin failures++; $display("FAIL wd_marker got=%h exp=dead", checkbits); end
    checks++; if (cycles !== 24'd10)      begin failures++; $display("FAIL wd_cycles got=%0d exp=10", cycles); end
    checks++; if (core_rst !== 1'b1)      begin failures++; $display("FAIL wd_core_rst got=%b exp=1", core_rst); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_addr;
    exp_addr = 8'd0;
    pulse_start(9'd4, 24'd0);
    ld_valid = 1'b1; ld_data = 32'hA000_0000;
    tick();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0) begin failures++; $display("FAIL stall_first got=%b@%0d exp=1@0", imem_we, imem_addr); end
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_we !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL stall_gap%0d got=%b/%b exp=0/1", i, imem_we, ld_ready); end
    end
    ld_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      ld_data = 32'hA000_0000 + 32'(i);
      tick();
      exp_addr = 8'(i);
      checks++; if (imem_we !== 1'b1 || imem_addr !== exp_addr || imem_wdata !== 32'hA000_0000 + 32'(i))
        begin failures++; $display("FAIL stall_word%0d got=%b@%0d=%h exp=1@%0d", i, imem_we, imem_addr, imem_wdata, exp_addr); end
    end
    ld_valid = 1'b0;
    tick();
    checks++; if (status !== 4'hA) begin failures++; $display("FAIL stall_run got=%h exp=a", status); end
    core_halt = 1'b1; core_result = 16'h0042;
    tick();
    core_halt = 1'b0;
    checks++; if (status !== 4'h5 || checkbits !== 16'h0042) begin failures++; $display("FAIL stall_done got=%h/%h exp=5/0042", status, checkbits); end
  endtask

  task automatic test_zero_len();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (status !== 4'h0) begin failures++; $display("FAIL zl_idle got=%h exp=0", status); end
    pulse_start(9'd0, 24'd0);
    checks++; if (status !== 4'h1 || ld_ready !== 1'b0 || busy !== 1'b1)
      begin failures++; $display("FAIL zl_arm got=%h/%b/%b exp=1/0/1", status, ld_ready, busy); end
    tick();
    checks++; if (status !== 4'hA || core_rst !== 1'b0) begin failures++; $display("FAIL zl_run got=%h/%b exp=a/0", status, core_rst); end
  endtask

  task automatic test_abort_reset();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    pulse_start(9'd3, 24'd0);
    ld_valid = 1'b1; ld_data = 32'h1111_1111;
    tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; ld_valid = 1'b0;
    checks++; if (status !== 4'h0)      begin failures++; $display("FAIL ab_status got=%h exp=0", status); end
    checks++; if (checkbits !== 16'h0)  begin failures++; $display("FAIL ab_checkbits got=%h exp=0", checkbits); end
    checks++; if (core_rst !== 1'b1)    begin failures++; $display("FAIL ab_core_rst got=%b exp=1", core_rst); end
    checks++; if (imem_we !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL ab_load_stop got=%b/%b exp=0/0", imem_we, ld_ready); end
    tick();
    checks++; if (status !== 4'h0 || busy !== 1'b0) begin failures++; $display("FAIL ab_start_ignored got=%h/%b exp=0/0", status, busy); end
    pulse_start(9'd0, 24'd0);
    ticks(6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (cycles !== 24'd5 || status !== 4'h0) begin failures++; $display("FAIL ab_cycles_hold got=%0d/%h exp=5/0", cycles, status); end
    pulse_start(9'd0, 24'd0);
    ticks(4);
    wb_rst_i = 1'b1;
    tick();
    expect_reset_values("midrst");
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_halt_vs_limit();
    pulse_start(9'd0, 24'd5);
    ticks(5);
    checks++; if (cycles !== 24'd4 || status !== 4'hA) begin failures++; $display("FAIL hl_pre got=%0d/%h exp=4/a", cycles, status); end
    core_halt = 1'b1; core_result = 16'hBEEF;
    tick();
    core_halt = 1'b0;
    checks++; if (status !== 4'h5)        begin failures++; $display("FAIL hl_status got=%h exp=5", status); end
    checks++; if (checkbits !== 16'hBEEF) begin failures++; $display("FAIL hl_result got=%h exp=beef", checkbits); end
    checks++; if (cycles !== 24'd5)       begin failures++; $display("FAIL hl_cycles got=%0d exp=5", cycles); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_halt();
    test_watchdog();
    test_stall();
    test_zero_len();
    test_abort_reset();
    test_halt_vs_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
